// File: rtl/pu_riscv_verilog_pkg.sv
// Shared RISC-V encodings and the PMA configuration bank's constants and FSM state type.
// No logic: localparams and types only.
// No flow control of its own.
package pu_riscv_verilog_pkg;

    localparam logic [1:0] OFF   = 2'd0;
    localparam logic [1:0] TOR   = 2'd1;
    localparam logic [1:0] NA4   = 2'd2;
    localparam logic [1:0] NAPOT = 2'd3;

    localparam int   PMA_LOCK_BIT = 15;
    localparam logic PMA_SEL_CFG  = 1'b0;
    localparam logic PMA_SEL_ADR  = 1'b1;

    typedef enum logic {
        PMACFG_IDLE = 1'b0,
        PMACFG_RESP = 1'b1
    } pmacfg_state_t;

endpackage

// File: rtl/pu_riscv_pmacfg_entry.sv
// One PMA cfg/address/lock register triple with write enables and change detect (lock: PU_RISCV_PMA_LOCK_EN).
// Latency: stored values update on the edge where a write enable is high; read/next/change outputs are combinational.
// Backpressure: none; the parent gates the write enables against locks.
module pu_riscv_pmacfg_entry
    import pu_riscv_verilog_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int PLEN = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we_i,
    input  logic              adr_we_i,
    input  logic [13:0]       cfg_wdata_i,
    input  logic              lock_wdata_i,
    input  logic [PLEN-3:0]   adr_wdata_i,
    output logic [13:0]       cfg_o,
    output logic [XLEN-1:0]   adr_o,
    output logic              lock_o,
    output logic [XLEN-1:0]   cfg_rd_o,
    output logic [XLEN-1:0]   cfg_nxt_o,
    output logic [XLEN-1:0]   adr_nxt_o,
    output logic              cfg_chg_o,
    output logic              adr_chg_o
);

    logic [13:0]     cfg_q, cfg_d;
    logic [PLEN-3:0] adr_q, adr_d;
    logic            lock_nxt;

`ifdef PU_RISCV_PMA_LOCK_EN
    logic lock_q, lock_d;

    // A lock is sticky: only reset can clear it.
    assign lock_nxt = lock_q | lock_wdata_i;
    assign lock_d   = cfg_we_i ? lock_nxt : lock_q;
    assign lock_o   = lock_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lock_q <= 1'b0;
        else     lock_q <= lock_d;
    end
`else
    logic unused_lock;
    assign unused_lock = lock_wdata_i;
    assign lock_nxt    = 1'b0;
    assign lock_o      = 1'b0;
`endif

    always_comb begin
        cfg_d = cfg_we_i ? cfg_wdata_i : cfg_q;
        adr_d = adr_we_i ? adr_wdata_i : adr_q;

        cfg_rd_o               = '0;
        cfg_rd_o[13:0]         = cfg_q;
        cfg_rd_o[PMA_LOCK_BIT] = lock_o;

        cfg_nxt_o               = '0;
        cfg_nxt_o[13:0]         = cfg_wdata_i;
        cfg_nxt_o[PMA_LOCK_BIT] = lock_nxt;

        adr_nxt_o = XLEN'(adr_wdata_i);
        cfg_chg_o = (cfg_wdata_i != cfg_q) | (lock_nxt != lock_o);
        adr_chg_o = (adr_wdata_i != adr_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_q <= '0;
            adr_q <= '0;
        end else begin
            cfg_q <= cfg_d;
            adr_q <= adr_d;
        end
    end

    assign cfg_o = cfg_q;
    assign adr_o = XLEN'(adr_q);

endmodule

// File: rtl/pu_riscv_pmacfg.sv
// PMA configuration bank: CSR/debug read/write of PMA_CNT cfg/address entries, optional locking (PU_RISCV_PMA_LOCK_EN).
// Latency: command accepted at edge N, table update and registered response in cycle N+1.
// Backpressure: cmd_ready_o low for the response cycle (one command per two cycles); response cannot be stalled.
module pu_riscv_pmacfg
    import pu_riscv_verilog_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int PLEN    = 64,
    parameter int PMA_CNT = 4,
    parameter int IDX_W   = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cmd_valid_i,
    output logic                            cmd_ready_o,
    input  logic                            cmd_we_i,
    input  logic                            cmd_sel_i,
    input  logic [IDX_W-1:0]                cmd_idx_i,
    input  logic [XLEN-1:0]                 cmd_wdata_i,
    output logic                            rsp_valid_o,
    output logic [XLEN-1:0]                 rsp_rdata_o,
    output logic                            rsp_err_o,
    output logic [PMA_CNT-1:0][13:0]        pma_cfg_o,
    output logic [PMA_CNT-1:0][XLEN-1:0]    pma_adr_o,
    output logic                            pma_update_o
);

    pmacfg_state_t state_q, state_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_err_q, rsp_err_d;
    logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
    logic            pma_update_q, pma_update_d;

    logic [PMA_CNT-1:0]           cfg_we, adr_we, lock, adr_locked, cfg_chg, adr_chg;
    logic [PMA_CNT-1:0][XLEN-1:0] cfg_rd, cfg_nxt, adr_nxt;

    logic            accept, hit, sel_chg, sel_locked;
    logic [XLEN-1:0] sel_rd, sel_nxt;

    logic unused_wdata;
    assign unused_wdata = ^cmd_wdata_i[XLEN-1:PLEN-2];

    for (genvar g = 0; g < PMA_CNT; g++) begin : g_ent
        pu_riscv_pmacfg_entry #(.XLEN(XLEN), .PLEN(PLEN)) u_entry (
            .clk          (clk),
            .rst          (rst),
            .cfg_we_i     (cfg_we[g]),
            .adr_we_i     (adr_we[g]),
            .cfg_wdata_i  (cmd_wdata_i[13:0]),
            .lock_wdata_i (cmd_wdata_i[PMA_LOCK_BIT]),
            .adr_wdata_i  (cmd_wdata_i[PLEN-3:0]),
            .cfg_o        (pma_cfg_o[g]),
            .adr_o        (pma_adr_o[g]),
            .lock_o       (lock[g]),
            .cfg_rd_o     (cfg_rd[g]),
            .cfg_nxt_o    (cfg_nxt[g]),
            .adr_nxt_o    (adr_nxt[g]),
            .cfg_chg_o    (cfg_chg[g]),
            .adr_chg_o    (adr_chg[g])
        );

        // A locked TOR entry also freezes the address below it, which is its range base.
        if (g < PMA_CNT-1) begin : g_tor
            assign adr_locked[g] = lock[g] | (lock[g+1] & (pma_cfg_o[g+1][1:0] == TOR));
        end else begin : g_last
            assign adr_locked[g] = lock[g];
        end
    end

    always_comb begin
        accept     = cmd_valid_i & (state_q == PMACFG_IDLE);
        hit        = 1'b0;
        sel_rd     = '0;
        sel_nxt    = '0;
        sel_chg    = 1'b0;
        sel_locked = 1'b0;
        cfg_we     = '0;
        adr_we     = '0;
        for (int i = 0; i < PMA_CNT; i++) begin
            if (cmd_idx_i == IDX_W'(i)) begin
                hit = 1'b1;
                if (cmd_sel_i == PMA_SEL_CFG) begin
                    sel_rd     = cfg_rd[i];
                    sel_nxt    = cfg_nxt[i];
                    sel_chg    = cfg_chg[i];
                    sel_locked = lock[i];
                    cfg_we[i]  = accept & cmd_we_i & ~lock[i];
                end else begin
                    sel_rd     = pma_adr_o[i];
                    sel_nxt    = adr_nxt[i];
                    sel_chg    = adr_chg[i];
                    sel_locked = adr_locked[i];
                    adr_we[i]  = accept & cmd_we_i & ~adr_locked[i];
                end
            end
        end

        state_d      = state_q;
        rsp_valid_d  = 1'b0;
        rsp_err_d    = 1'b0;
        rsp_rdata_d  = '0;
        pma_update_d = 1'b0;
        case (state_q)
            PMACFG_IDLE: begin
                if (accept) begin
                    state_d     = PMACFG_RESP;
                    rsp_valid_d = 1'b1;
                    if (!hit) begin
                        rsp_err_d = 1'b1;
                    end else if (cmd_we_i && sel_locked) begin
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = sel_rd;
                    end else if (cmd_we_i) begin
                        rsp_rdata_d  = sel_nxt;
                        pma_update_d = sel_chg;
                    end else begin
                        rsp_rdata_d = sel_rd;
                    end
                end
            end
            default: state_d = PMACFG_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= PMACFG_IDLE;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= '0;
            pma_update_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_rdata_q  <= rsp_rdata_d;
            pma_update_q <= pma_update_d;
        end
    end

    assign cmd_ready_o  = (state_q == PMACFG_IDLE);
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_err_o    = rsp_err_q;
    assign rsp_rdata_o  = rsp_rdata_q;
    assign pma_update_o = pma_update_q;

endmodule

// File: tb/tb_pu_riscv_pmacfg.sv
// Bench for pu_riscv_pmacfg: directed commands with literal expectations plus a per-cycle table/response model.
module tb_pu_riscv_pmacfg;

`ifdef PU_RISCV_PMA_LOCK_EN
    localparam bit LK = 1'b1;
`else
    localparam bit LK = 1'b0;
`endif
    localparam logic [63:0] AMASK = 64'h3FFF_FFFF_FFFF_FFFF;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cmd_valid_i = 1'b0;
    logic             cmd_ready_o;
    logic             cmd_we_i = 1'b0;
    logic             cmd_sel_i = 1'b0;
    logic [3:0]       cmd_idx_i = '0;
    logic [63:0]      cmd_wdata_i = '0;
    logic             rsp_valid_o;
    logic [63:0]      rsp_rdata_o;
    logic             rsp_err_o;
    logic [3:0][13:0] pma_cfg_o;
    logic [3:0][63:0] pma_adr_o;
    logic             pma_update_o;

    pu_riscv_pmacfg #(.XLEN(64), .PLEN(64), .PMA_CNT(4), .IDX_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_we_i     (cmd_we_i),
        .cmd_sel_i    (cmd_sel_i),
        .cmd_idx_i    (cmd_idx_i),
        .cmd_wdata_i  (cmd_wdata_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o),
        .pma_cfg_o    (pma_cfg_o),
        .pma_adr_o    (pma_adr_o),
        .pma_update_o (pma_update_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    bit run   = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: plain arrays of entry contents; a command is taken whenever the previous one is not in its response cycle.
    logic [13:0] m_cfg [4];
    logic [63:0] m_adr [4];
    logic        m_lock[4];
    bit          m_busy;
    bit          e_vld, e_err, e_upd;
    logic [63:0] e_rd;

    task model_apply();
        int          ix;
        logic [63:0] cur, nw;
        bit          locked;
        ix = int'(cmd_idx_i);
        if (ix >= 4) begin
            e_err = 1'b1;
        end else if (cmd_sel_i == 1'b0) begin
            cur = {48'b0, m_lock[ix], 1'b0, m_cfg[ix]};
            if (!cmd_we_i) e_rd = cur;
            else if (m_lock[ix]) begin
                e_err = 1'b1;
                e_rd  = cur;
            end else begin
                nw = {48'b0, (LK ? cmd_wdata_i[15] : 1'b0), 1'b0, cmd_wdata_i[13:0]};
                e_upd      = (nw != cur);
                m_cfg[ix]  = cmd_wdata_i[13:0];
                m_lock[ix] = nw[15];
                e_rd       = nw;
            end
        end else begin
            cur    = m_adr[ix];
            locked = m_lock[ix];
            if (ix < 3) locked = locked || (m_lock[ix+1] && (m_cfg[ix+1][1:0] == 2'd1));
            if (!cmd_we_i) e_rd = cur;
            else if (locked) begin
                e_err = 1'b1;
                e_rd  = cur;
            end else begin
                nw        = cmd_wdata_i & AMASK;
                e_upd     = (nw != cur);
                m_adr[ix] = nw;
                e_rd      = nw;
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_cfg[i]  = '0;
                m_adr[i]  = '0;
                m_lock[i] = 1'b0;
            end
            m_busy = 1'b0;
            e_vld = 1'b0; e_err = 1'b0; e_upd = 1'b0; e_rd = '0;
        end else begin
            e_vld = 1'b0; e_err = 1'b0; e_upd = 1'b0; e_rd = '0;
            if (m_busy) m_busy = 1'b0;
            else if (cmd_valid_i) begin
                m_busy = 1'b1;
                e_vld  = 1'b1;
                model_apply();
            end
        end
    end

    always @(negedge clk) begin
        if (run && !rst) begin
            chk("m_ready", cmd_ready_o, !m_busy);
            chk("m_rsp_valid", rsp_valid_o, e_vld);
            chk("m_update", pma_update_o, e_upd);
            if (e_vld) begin
                chk("m_rdata", rsp_rdata_o, e_rd);
                chk("m_err", rsp_err_o, e_err);
            end
            for (int i = 0; i < 4; i++) begin
                chk("m_cfg", 64'(pma_cfg_o[i]), 64'(m_cfg[i]));
                chk("m_adr", pma_adr_o[i], m_adr[i]);
            end
        end
    end

    task automatic cmd(input string nm, input bit we, input bit sel, input logic [3:0] idx,
                       input logic [63:0] wd, input logic [63:0] xr, input bit xe, input bit xu);
        int n;
        @(negedge clk);
        cmd_valid_i = 1'b1; cmd_we_i = we; cmd_sel_i = sel; cmd_idx_i = idx; cmd_wdata_i = wd;
        n = 0;
        while (!cmd_ready_o && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_ready"}, cmd_ready_o, 1'b1);
        @(posedge clk);
        #1 cmd_valid_i = 1'b0;
        @(negedge clk);
        chk({nm, "_vld"}, rsp_valid_o, 1'b1);
        chk({nm, "_rdata"}, rsp_rdata_o, xr);
        chk({nm, "_err"}, rsp_err_o, xe);
        chk({nm, "_upd"}, pma_update_o, xu);
    endtask

    initial begin
        int  nacc;
        bit  prev;
        #2 rst = 1'b1;
        #20 rst = 1'b0;
        run = 1'b1;
        @(negedge clk);
        chk("rst_ready", cmd_ready_o, 1'b1);
        chk("rst_vld", rsp_valid_o, 1'b0);
        chk("rst_err", rsp_err_o, 1'b0);
        chk("rst_rdata", rsp_rdata_o, 64'h0);
        chk("rst_upd", pma_update_o, 1'b0);

        cmd("rd_cfg2", 0, 0, 4'd2, 64'h0, 64'h0, 0, 0);
        cmd("wr_cfg1", 1, 0, 4'd1, 64'h0F01, 64'h0F01, 0, 1);
        chk("cfg1_table", 64'(pma_cfg_o[1]), 64'h0F01);
        cmd("rewr_cfg1", 1, 0, 4'd1, 64'h0F01, 64'h0F01, 0, 0);
        cmd("wr_adr0", 1, 1, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h3FFF_FFFF_FFFF_FFFF, 0, 1);
        cmd("rd_adr0", 0, 1, 4'd0, 64'h0, 64'h3FFF_FFFF_FFFF_FFFF, 0, 0);
        cmd("wr_adr2", 1, 1, 4'd2, 64'h1234, 64'h1234, 0, 1);
        cmd("wr_cfg3_lock", 1, 0, 4'd3, 64'h8001, LK ? 64'h8001 : 64'h0001, 0, 1);
        cmd("wr_adr2_tor", 1, 1, 4'd2, 64'h5555, LK ? 64'h1234 : 64'h5555, LK, !LK);
        chk("adr2_table", pma_adr_o[2], LK ? 64'h1234 : 64'h5555);
        cmd("wr_adr3_lock", 1, 1, 4'd3, 64'h77, LK ? 64'h0 : 64'h77, LK, !LK);
        cmd("wr_adr1_free", 1, 1, 4'd1, 64'h99, 64'h99, 0, 1);
        cmd("wr_cfg3_again", 1, 0, 4'd3, 64'h0003, LK ? 64'h8001 : 64'h0003, LK, !LK);
        cmd("wr_idx5", 1, 0, 4'd5, 64'hFFFF, 64'h0, 1, 0);
        cmd("rd_idx15", 0, 1, 4'd15, 64'h0, 64'h0, 1, 0);

        // Back-to-back: valid held high, one acceptance every other cycle.
        @(negedge clk);
        cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_sel_i = 1'b0; cmd_idx_i = 4'd1;
        nacc = 0;
        prev = cmd_ready_o;
        chk("b2b_ready_start", cmd_ready_o, 1'b1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rsp_valid_o) nacc++;
            chk("b2b_ready_toggle", cmd_ready_o, !prev);
            prev = cmd_ready_o;
        end
        cmd_valid_i = 1'b0;
        chk("b2b_accepts", nacc, 4);
        @(negedge clk);

        // Reset arriving during the response cycle.
        cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_sel_i = 1'b0; cmd_idx_i = 4'd0; cmd_wdata_i = 64'h5;
        chk("rr_ready", cmd_ready_o, 1'b1);
        @(posedge clk);
        #1 cmd_valid_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rr_vld", rsp_valid_o, 1'b0);
        chk("rr_upd", pma_update_o, 1'b0);
        chk("rr_cfg0", 64'(pma_cfg_o[0]), 64'h0);
        #2 rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("rr_post_vld", rsp_valid_o, 1'b0);
            chk("rr_post_upd", pma_update_o, 1'b0);
        end
        cmd("rd_cfg3_after_rst", 0, 0, 4'd3, 64'h0, 64'h0, 0, 0);
        cmd("wr_adr2_after_rst", 1, 1, 4'd2, 64'hABC, 64'hABC, 0, 1);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_chk, n_err);
        $fatal(1);
    end

endmodule
